ising_weight_loader: RTL and testbench
======================================

// Module: ising_weight_loader
// PURPOSE
//  Host-side front end for the Ising core: accepts coupling weights one beat at a time over a
//  valid/ready stream and packs them into the flat weight vector for core_matrix.
//  Releases the core/sampler reset for a fixed anneal window, then captures the sampler phase.
//  Returns that phase over a valid/ready result port.
//  Sits between the host bus and top-level core_matrix + sample; drives their weights and rstn.
// PARAMETERS
//  N            3     number of spins/oscillators
//  NUM_WEIGHTS  5     number of weight codes; code (NUM_WEIGHTS-1)/2 = zero coupling
//  RUN_CYCLES   1024  clk cycles core_rstn is held high per run (>=1)
//  localparam WBITS=$clog2(NUM_WEIGHTS), NPAIRS=N*(N-1)/2, WVEC=WBITS*NPAIRS, CW=$clog2(RUN_CYCLES+1)
// PORTS
//  clk        in   1      single clock for all state
//  rstn       in   1      reset, asynchronous, active-low
//  clear      in   1      sync abort: return to LOAD, slot index 0
//  wt_valid   in   1      weight beat valid
//  wt_ready   out  1      weight beat accepted when wt_valid & wt_ready
//  wt_data    in   WBITS  weight code for current pair slot
//  start      in   1      begin a run (honoured only in ARMED)
//  weights    out  WVEC   packed weights to core_matrix; slot i = weights[i*WBITS +: WBITS]
//  core_rstn  out  1      active-low reset to core_matrix and sample
//  phase_in   in   N      phase from sampler (clk-synchronous)
//  res_valid  out  1      captured phase valid
//  res_ready  in   1      host accepts result
//  res_phase  out  N      captured phase
//  busy       out  1      high in RUN or DONE
//  err        out  1      sticky range error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rstn low): state=LOAD, idx=0, weights=0, core_rstn=0, wt_ready=0, res_valid=0,
//   res_phase=0, busy=0, err=0. All outputs registered; wt_ready rises on first clk edge after release.
//  FSM LOAD->ARMED->RUN->DONE->ARMED.
//   LOAD: wt_ready=1. Each accepted beat writes slot idx, idx++.
//    The beat with idx==NPAIRS-1 -> ARMED, idx=0, wt_ready=0 next cycle.
//   ARMED: wt_ready=0; weights held stable.
//    start -> RUN: counter=0, core_rstn=1 from the next cycle.
//   RUN: counter increments every cycle.
//    At edge where counter==RUN_CYCLES-1: res_phase<=phase_in, core_rstn<=0, res_valid<=1 -> DONE.
//    core_rstn is high for exactly RUN_CYCLES cycles.
//    res_valid rises RUN_CYCLES+1 edges after the start-sampling edge.
//   DONE: res_valid/res_phase held until res_valid&res_ready.
//    Handshake edge: res_valid<=0 -> ARMED; same weights, rerun with start.
//  start outside ARMED is ignored (no queueing). wt_valid outside LOAD is ignored.
//  clear (any state, priority over start, beats and result handshake):
//   next edge state=LOAD, idx=0, core_rstn=0, res_valid=0, err=0; weights keep old values until overwritten.
//  clear during RUN aborts the run with no result.
//  weights never change in ARMED/RUN/DONE. No wrap of idx past NPAIRS-1.
//  rstn asserted mid-run: immediate async return to reset values, core_rstn=0.
// CONFIGURATION
//  ISING_WEIGHT_RANGE_CHECK_EN defined:
//   Beat with wt_data>=NUM_WEIGHTS is still accepted; slot written with (NUM_WEIGHTS-1)/2; err<=1 sticky.
//   While err=1, start in ARMED is ignored. Only clear or rstn clears err.
//  Undefined: wt_data written verbatim; err tied 0; start never blocked.
// TESTING
//  N=3,NUM_WEIGHTS=5,RUN_CYCLES=8: beats 1,2,3 -> weights=9'b011_010_001; ARMED; wt_ready=0.
//  start pulse at edge k -> core_rstn high edges k+1..k+8; res_valid at k+9; res_phase=phase_in at k+8.
//  Result flow control: res_ready low 5 cycles -> res_valid/res_phase stable; handshake -> ARMED.
//   Then start -> second identical run.
//  Control edge cases: start during LOAD (after 1 beat) ignored.
//   clear at RUN counter=3 -> core_rstn=0, LOAD, no res_valid.
//   clear+start same cycle -> LOAD.
//  With ISING_WEIGHT_RANGE_CHECK_EN: beat 7 in slot 1 -> slot 1=2, err=1, start ignored.
//   clear -> err=0.
//  Reset: rstn low mid-RUN -> all outputs 0 asynchronously.
//   After release, wt_ready=1 one edge later; weights=0.

Source files
------------

// File: rtl/ising_weight_loader.sv
// Host front end for the Ising core: streams coupling weights in, times one anneal run, returns the phase.
// Optional ISING_WEIGHT_RANGE_CHECK_EN: out-of-range codes load as zero coupling and raise a sticky err.
module ising_weight_loader #(
    parameter int N           = 3,
    parameter int NUM_WEIGHTS = 5,
    parameter int RUN_CYCLES  = 1024,
    localparam int WBITS      = $clog2(NUM_WEIGHTS),
    localparam int NPAIRS     = N * (N - 1) / 2,
    localparam int WVEC       = WBITS * NPAIRS,
    localparam int CW         = $clog2(RUN_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             wt_valid,
    output logic             wt_ready,
    input  logic [WBITS-1:0] wt_data,
    input  logic             start,
    output logic [WVEC-1:0]  weights,
    output logic             core_rstn,
    input  logic [N-1:0]     phase_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_phase,
    output logic             busy,
    output logic             err
);

    localparam int IW = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NPAIRS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(RUN_CYCLES - 1);

`ifdef ISING_WEIGHT_RANGE_CHECK_EN
    localparam logic [WBITS:0]   NW_LIMIT  = (WBITS + 1)'(NUM_WEIGHTS);
    localparam logic [WBITS-1:0] ZERO_CODE = WBITS'((NUM_WEIGHTS - 1) / 2);
`endif

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WVEC-1:0]   weights_q, weights_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              core_rstn_q, core_rstn_d;
    logic              wt_ready_q, wt_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [N-1:0]      res_phase_q, res_phase_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [WBITS-1:0]  beat_data;
    logic              start_ok;

    // NOTE: every next-state signal gets its default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        weights_d   = weights_q;
        cnt_d       = cnt_q;
        core_rstn_d = core_rstn_q;
        res_valid_d = res_valid_q;
        res_phase_d = res_phase_q;
        err_d       = err_q;
        beat_data   = wt_data;
`ifdef ISING_WEIGHT_RANGE_CHECK_EN
        start_ok    = !err_q;
`else
        start_ok    = 1'b1;
`endif

        if (clear) begin
            // Abort wins over everything; the loaded weights survive until overwritten.
            state_d     = LOAD;
            idx_d       = '0;
            cnt_d       = '0;
            core_rstn_d = 1'b0;
            res_valid_d = 1'b0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (wt_valid && wt_ready_q) begin
`ifdef ISING_WEIGHT_RANGE_CHECK_EN
                        if ({1'b0, wt_data} >= NW_LIMIT) begin
                            beat_data = ZERO_CODE;
                            err_d     = 1'b1;
                        end
`endif
                        weights_d[int'(idx_q)*WBITS +: WBITS] = beat_data;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = ARMED;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (start && start_ok) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    // First RUN cycle only releases the core; the window is counted from there.
                    if (!core_rstn_q) begin
                        core_rstn_d = 1'b1;
                    end else if (cnt_q == LAST_CNT) begin
                        res_phase_d = phase_in;
                        core_rstn_d = 1'b0;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (res_valid_q && res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = ARMED;
                    end
                end
                default: state_d = LOAD;
            endcase
        end

        wt_ready_d = (state_d == LOAD);
        busy_d     = (state_d == RUN) || (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            weights_q   <= '0;
            cnt_q       <= '0;
            core_rstn_q <= 1'b0;
            wt_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_phase_q <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            weights_q   <= weights_d;
            cnt_q       <= cnt_d;
            core_rstn_q <= core_rstn_d;
            wt_ready_q  <= wt_ready_d;
            res_valid_q <= res_valid_d;
            res_phase_q <= res_phase_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign wt_ready  = wt_ready_q;
    assign weights   = weights_q;
    assign core_rstn = core_rstn_q;
    assign res_valid = res_valid_q;
    assign res_phase = res_phase_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ising_weight_loader.sv
// Directed bench for ising_weight_loader with N=3, NUM_WEIGHTS=5, RUN_CYCLES=8.
// Expectations for the optional range check follow ISING_WEIGHT_RANGE_CHECK_EN when defined.
module tb_ising_weight_loader;

    localparam int N           = 3;
    localparam int NUM_WEIGHTS = 5;
    localparam int RUN_CYCLES  = 8;
    localparam int WBITS       = 3;
    localparam int WVEC        = 9;

    logic             clk = 1'b0;
    logic             rstn;
    logic             clear;
    logic             wt_valid;
    logic             wt_ready;
    logic [WBITS-1:0] wt_data;
    logic             start;
    logic [WVEC-1:0]  weights;
    logic             core_rstn;
    logic [N-1:0]     phase_in;
    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     res_phase;
    logic             busy;
    logic             err;

    int tests = 0;
    int fails = 0;

    ising_weight_loader #(
        .N(N),
        .NUM_WEIGHTS(NUM_WEIGHTS),
        .RUN_CYCLES(RUN_CYCLES)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .clear(clear),
        .wt_valid(wt_valid),
        .wt_ready(wt_ready),
        .wt_data(wt_data),
        .start(start),
        .weights(weights),
        .core_rstn(core_rstn),
        .phase_in(phase_in),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_phase(res_phase),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [WBITS-1:0] d);
        wt_valid = 1'b1;
        wt_data  = d;
        tick();
        wt_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int n_hi;

        rstn      = 1'b0;
        clear     = 1'b0;
        wt_valid  = 1'b0;
        wt_data   = '0;
        start     = 1'b0;
        phase_in  = '0;
        res_ready = 1'b0;

        // Reset values
        tick();
        check("rst_wt_ready", 32'(wt_ready), 32'd0);
        check("rst_core_rstn", 32'(core_rstn), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_phase", 32'(res_phase), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_weights", 32'(weights), 32'h000);

        rstn = 1'b1;
        #1;
        check("rel_wt_ready_low", 32'(wt_ready), 32'd0);
        tick();
        check("rel_wt_ready_high", 32'(wt_ready), 32'd1);

        // One beat, then a start while still loading must be ignored
        beat(3'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_start_busy", 32'(busy), 32'd0);
        check("load_start_core_rstn", 32'(core_rstn), 32'd0);
        check("load_start_wt_ready", 32'(wt_ready), 32'd1);

        beat(3'd2);
        check("mid_wt_ready", 32'(wt_ready), 32'd1);
        beat(3'd3);
        check("armed_weights", 32'(weights), 32'h0D1);
        check("armed_wt_ready", 32'(wt_ready), 32'd0);

        // Beat offered while armed is ignored
        beat(3'd0);
        check("armed_beat_ignored", 32'(weights), 32'h0D1);

        // Run 1 with explicit cycle-by-cycle timing
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_k_busy", 32'(busy), 32'd1);
        check("run_k_core_rstn", 32'(core_rstn), 32'd0);
        for (int i = 1; i <= RUN_CYCLES; i++) begin
            tick();
            check($sformatf("run_core_rstn_k%0d", i), 32'(core_rstn), 32'd1);
            check($sformatf("run_res_valid_k%0d", i), 32'(res_valid), 32'd0);
        end
        phase_in = 3'b110;
        tick();
        phase_in = 3'b011;
        check("run_done_res_valid", 32'(res_valid), 32'd1);
        check("run_done_res_phase", 32'(res_phase), 32'b110);
        check("run_done_core_rstn", 32'(core_rstn), 32'd0);
        check("run_done_busy", 32'(busy), 32'd1);
        check("run_weights_stable", 32'(weights), 32'h0D1);

        // Back-pressure on result; a start in DONE is ignored
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            check($sformatf("hold_res_valid_%0d", i), 32'(res_valid), 32'd1);
            check($sformatf("hold_res_phase_%0d", i), 32'(res_phase), 32'b110);
        end
        start = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("hs_res_valid", 32'(res_valid), 32'd0);
        check("hs_busy", 32'(busy), 32'd0);

        // Second identical run, bounded wait
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc  = 0;
        n_hi = 0;
        while (!res_valid && cyc < 40) begin
            tick();
            cyc++;
            if (core_rstn) n_hi++;
        end
        check("run2_latency", 32'(cyc), 32'd9);
        check("run2_core_rstn_cycles", 32'(n_hi), 32'd8);
        check("run2_res_phase", 32'(res_phase), 32'b011);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("run2_hs", 32'(res_valid), 32'd0);

        // Clear at RUN counter==3 aborts without a result
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_clear_core_rstn", 32'(core_rstn), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_core_rstn", 32'(core_rstn), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_wt_ready", 32'(wt_ready), 32'd1);
        check("clr_weights_kept", 32'(weights), 32'h0D1);
        cyc = 0;
        repeat (12) begin
            tick();
            if (res_valid) cyc++;
        end
        check("clr_no_result", 32'(cyc), 32'd0);

        // clear and start together land in LOAD
        beat(3'd4);
        beat(3'd0);
        beat(3'd2);
        check("reload_weights", 32'(weights), 32'h084);
        check("reload_armed", 32'(wt_ready), 32'd0);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("clr_start_wt_ready", 32'(wt_ready), 32'd1);
        check("clr_start_busy", 32'(busy), 32'd0);
        check("clr_start_core_rstn", 32'(core_rstn), 32'd0);

        // Out-of-range code in slot 1
        beat(3'd1);
        beat(3'd7);
        beat(3'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef ISING_WEIGHT_RANGE_CHECK_EN
        check("range_weights", 32'(weights), 32'h0D1);
        check("range_err", 32'(err), 32'd1);
        check("range_start_blocked", 32'(busy), 32'd0);
`else
        check("range_weights", 32'(weights), 32'h0F9);
        check("range_err", 32'(err), 32'd0);
        check("range_start_taken", 32'(busy), 32'd1);
`endif
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("range_clr_err", 32'(err), 32'd0);
        check("range_clr_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a run
        beat(3'd1);
        beat(3'd1);
        beat(3'd1);
        check("rst_run_weights", 32'(weights), 32'h049);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("rst_run_core_rstn_pre", 32'(core_rstn), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_core_rstn", 32'(core_rstn), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_weights", 32'(weights), 32'h000);
        check("async_wt_ready", 32'(wt_ready), 32'd0);
        check("async_res_valid", 32'(res_valid), 32'd0);
        tick();
        rstn = 1'b1;
        #1;
        check("post_rst_wt_ready_low", 32'(wt_ready), 32'd0);
        tick();
        check("post_rst_wt_ready_high", 32'(wt_ready), 32'd1);
        check("post_rst_weights", 32'(weights), 32'h000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
